// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the receive path (kbd_cntrl).
//   ps2_tx_state_e  host transmitter FSM states
//   ERR_*           err_code values reported to irqsta
//   FRAME_FALLS     device clock falls that carry data, parity and stop bits
//   CMD_*           common host-to-keyboard command bytes
//   odd_parity()    parity bit that makes the total number of ones odd
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StSend,
    StAck,
    StWaitIdle,
    StDone,
    StErr
  } ps2_tx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned FRAME_FALLS = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: SYNC_STAGES-flop synchronizer for one raw PS/2 line plus falling-edge detect.
//   clk, rst_n  system clock, async active-low reset
//   line        raw pin (asynchronous)
//   sync        synchronized level
//   fall        one-cycle pulse when sync goes 1 -> 0
// Flops reset to 1 because idle PS/2 lines are pulled high.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic sync,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter, sends one command byte to the keyboard.
//   clk, rst_n           system clock, async active-low reset
//   tx_data, tx_valid    command byte and request (accepted while tx_ready)
//   tx_ready             high only when idle
//   kbd_clk_in/data_in   raw shared open-drain lines
//   kbd_clk_oe/data_oe   1 = pull the line low (top level builds the inout)
//   tx_busy              transfer in progress; the receive path drops frames while high
//   tx_done, tx_err      one-cycle completion / failure pulses
//   err_code             ERR_NACK or ERR_TIMEOUT, held until the next accept
// Build option: define PS2_TX_WATCHDOG_EN to abort a transfer after TIMEOUT_CYCLES.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kbd_clk_in,
  input  logic       kbd_data_in,
  output logic       kbd_clk_oe,
  output logic       kbd_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  ps2_tx_state_e   state_q;
  logic [7:0]      data_q;
  logic            parity_q;
  logic [3:0]      bit_idx_q;
  logic [InhW-1:0] inh_cnt_q;

  logic clk_sync, clk_fall, data_sync, data_fall_unused;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .line (kbd_clk_in),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .line (kbd_data_in),
    .sync (data_sync),
    .fall (data_fall_unused)
  );

`ifdef PS2_TX_WATCHDOG_EN
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WdW-1:0] wd_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tx_ready    <= 1'b1;
      kbd_clk_oe  <= 1'b0;
      kbd_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      err_code    <= ERR_NONE;
      data_q      <= 8'h00;
      parity_q    <= 1'b0;
      bit_idx_q   <= 4'd0;
      inh_cnt_q   <= '0;
`ifdef PS2_TX_WATCHDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
`ifdef PS2_TX_WATCHDOG_EN
      wd_q    <= (state_q == StIdle) ? '0 : wd_q + WdW'(1);
`endif
      unique case (state_q)
        StIdle: begin
          if (tx_valid) begin
            data_q     <= tx_data;
            parity_q   <= odd_parity(tx_data);
            bit_idx_q  <= 4'd0;
            inh_cnt_q  <= '0;
            err_code   <= ERR_NONE;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            kbd_clk_oe <= 1'b1;
            state_q    <= StInhibit;
          end
        end
        StInhibit: begin
          if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
            kbd_data_oe <= 1'b1;  // start bit
            state_q     <= StRts;
          end else begin
            inh_cnt_q <= inh_cnt_q + InhW'(1);
          end
        end
        StRts: begin
          kbd_clk_oe <= 1'b0;  // hand the clock to the device
          state_q    <= StSend;
        end
        StSend: begin
          if (clk_fall) begin
            bit_idx_q <= bit_idx_q + 4'd1;
            if (!bit_idx_q[3]) begin
              kbd_data_oe <= ~data_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'(FRAME_FALLS - 2)) begin
              kbd_data_oe <= ~parity_q;
            end else begin
              kbd_data_oe <= 1'b0;  // stop bit: line floats high
              state_q     <= StAck;
            end
          end
        end
        StAck: begin
          if (clk_fall) begin
            if (!data_sync) begin
              state_q <= StWaitIdle;
            end else begin
              tx_err   <= 1'b1;
              err_code <= ERR_NACK;
              state_q  <= StErr;
            end
          end
        end
        StWaitIdle: begin
          if (clk_sync && data_sync) begin
            tx_done <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone, StErr: begin
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
`ifdef PS2_TX_WATCHDOG_EN
      // Later assignments win, so a timeout overrides an ACK sampled in the same cycle.
      if (state_q != StIdle && state_q != StDone && state_q != StErr &&
          wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
        kbd_clk_oe  <= 1'b0;
        kbd_data_oe <= 1'b0;
        tx_done     <= 1'b0;
        tx_err      <= 1'b1;
        err_code    <= ERR_TIMEOUT;
        state_q     <= StErr;
      end
`endif
    end
  end

endmodule
